// File: rtl/segment_hex_mux.sv
// Multiplexed common-anode 7-segment hex driver with PWM brightness and frame-synchronous value update.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module segment_hex_mux #(
    parameter int NUM_DIGITS = 8,
    parameter int CNT_W      = 16,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] hex_value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [7:0]              cathode_array,
    output logic [NUM_DIGITS-1:0]   anode_array,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [7:0]              cathode_q, cathode_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_done_q, frame_done_d;

    logic                    at_tc, at_last, at_boundary;
    logic [NUM_DIGITS-1:0]   digit_keep;
    logic [3:0]              cur_nibble;
    logic                    digit_lit;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            default: hex_to_seg = 8'h8E;
        endcase
    endfunction

`ifdef SEG_LZB_EN
    // A digit stays visible if it or any higher nibble is non-zero, its dp is set, or it is digit 0.
    logic [NUM_DIGITS-1:0] nibble_nz;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign nibble_nz[gi]  = |shadow_val_q[4*gi +: 4];
        assign digit_keep[gi] = (gi == 0) || shadow_dp_q[gi] || (|(nibble_nz >> gi));
    end
`else
    assign digit_keep = '1;
`endif

    assign at_tc       = (cnt_q == {CNT_W{1'b1}});
    assign at_last     = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign at_boundary = at_tc && at_last;

    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        stage_val_d  = stage_val_q;
        stage_dp_d   = stage_dp_q;
        pending_d    = pending_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        frame_done_d = at_boundary;
        if (at_tc) begin
            idx_d = at_last ? '0 : idx_q + IDX_W'(1);
        end
        // A load landing on the boundary bypasses staging so it is shown from the very next frame.
        if (load) begin
            if (at_boundary) begin
                shadow_val_d = hex_value;
                shadow_dp_d  = dp_in;
                pending_d    = 1'b0;
            end else begin
                stage_val_d = hex_value;
                stage_dp_d  = dp_in;
                pending_d   = 1'b1;
            end
        end else if (at_boundary && pending_q) begin
            shadow_val_d = stage_val_q;
            shadow_dp_d  = stage_dp_q;
            pending_d    = 1'b0;
        end
    end

    always_comb begin
        cur_nibble = shadow_val_q[{idx_q, 2'b00} +: 4];
        digit_lit  = digit_en[idx_q] && digit_keep[idx_q]
                     && (cnt_q[CNT_W-1 -: BRIGHT_W] <= brightness);
        cathode_d  = 8'hFF;
        anode_d    = '1;
        if (digit_lit) begin
            cathode_d = hex_to_seg(cur_nibble);
            if (shadow_dp_q[idx_q]) begin
                cathode_d[7] = 1'b0;
            end
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            pending_q    <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            cathode_q    <= 8'hFF;
            anode_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_val_q  <= stage_val_d;
            stage_dp_q   <= stage_dp_d;
            pending_q    <= pending_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            cathode_q    <= cathode_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cathode_array = cathode_q;
    assign anode_array   = anode_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_segment_hex_mux.sv
// Self-checking bench for segment_hex_mux (8 digits, 4-bit slot counter, 2-bit brightness).
// Every output cycle is compared with a time-indexed model of what the display should show.
module tb_segment_hex_mux;

    logic        clk;
    logic        resetn;
    logic [31:0] hex_value;
    logic [7:0]  dp_in;
    logic        load;
    logic [7:0]  digit_en;
    logic [1:0]  brightness;
    logic [7:0]  cathode_array;
    logic [7:0]  anode_array;
    logic        frame_done;

    segment_hex_mux #(.NUM_DIGITS(8), .CNT_W(4), .BRIGHT_W(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .hex_value     (hex_value),
        .dp_in         (dp_in),
        .load          (load),
        .digit_en      (digit_en),
        .brightness    (brightness),
        .cathode_array (cathode_array),
        .anode_array   (anode_array),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tl;
        logic [31:0] v;
        logic [7:0]  dp;
    } load_t;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic [1:0]  br;
        int          digit;
        logic [7:0]  exp_cath;
        logic [7:0]  exp_an;
    } vec_t;

    load_t       lq[$];
    logic [7:0]  seg_tab [16];
    vec_t        vecs [8];
    int          checks   = 0;
    int          failures = 0;
    int          cur_t    = 0;
    int          last_t   = -1;

    // Scan position is a pure function of time since reset; the shown value is the
    // most recent load issued before the start of the frame containing that time.
    function automatic void model(input int t, output logic [7:0] ec,
                                  output logic [7:0] ea, output logic efd);
        logic [31:0] v;
        logic [7:0]  d;
        logic [3:0]  nib;
        logic        lit;
        int          frame_start, idx, slot;
        v = 32'h0;
        d = 8'h0;
        frame_start = (t / 128) * 128;
        for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].tl < frame_start) begin
                v = lq[i].v;
                d = lq[i].dp;
                break;
            end
        end
        idx  = (t / 16) % 8;
        slot = (t % 16) / 4;
        lit  = digit_en[idx] && (slot <= int'(brightness));
`ifdef SEG_LZB_EN
        if (!(idx == 0 || d[idx] || ((v >> (4 * idx)) != 32'h0))) lit = 1'b0;
`endif
        nib = v[4*idx +: 4];
        ec  = lit ? (seg_tab[nib] & (d[idx] ? 8'h7F : 8'hFF)) : 8'hFF;
        ea  = lit ? ~(8'h01 << idx) : 8'hFF;
        efd = ((t % 128) == 127);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: record any load, advance, then compare all outputs with the model.
    task automatic cycle();
        logic [7:0] ec, ea;
        logic       efd;
        if (resetn && load) begin
            lq.push_back('{cur_t, hex_value, dp_in});
            $display("load t=%0d value=%h dp=%h", cur_t, hex_value, dp_in);
        end
        @(posedge clk);
        #1;
        checks++;
        if (!resetn) begin
            cur_t  = 0;
            last_t = -1;
            lq.delete();
            if (cathode_array !== 8'hFF || anode_array !== 8'hFF || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_state: cath=%h an=%h fd=%b expected FF FF 0",
                         cathode_array, anode_array, frame_done);
            end
        end else begin
            model(cur_t, ec, ea, efd);
            if (cathode_array !== ec || anode_array !== ea || frame_done !== efd) begin
                failures++;
                $display("FAIL scan t=%0d: cath=%h an=%h fd=%b expected %h %h %b",
                         cur_t, cathode_array, anode_array, frame_done, ec, ea, efd);
            end
            last_t = cur_t;
            cur_t++;
        end
        load = 1'b0;
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (last_t != target && guard < 2000) begin
            cycle();
            guard++;
        end
        if (last_t != target) begin
            checks++;
            failures++;
            $display("FAIL run_until: reached t=%0d expected t=%0d", last_t, target);
        end
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        repeat (n) cycle();
        resetn = 1'b1;
    endtask

    initial begin
        int lit_cnt;
        int bad_seen;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vecs[0] = '{32'h89ABCDEF, 8'h00, 8'hFF, 2'd3, 0, 8'h8E, 8'hFE};
        vecs[1] = '{32'h89ABCDEF, 8'h00, 8'hFF, 2'd3, 7, 8'h80, 8'h7F};
        vecs[2] = '{32'h89ABCDEF, 8'h00, 8'hFF, 2'd3, 3, 8'hC6, 8'hF7};
        vecs[3] = '{32'h00001234, 8'h01, 8'h0F, 2'd3, 0, 8'h19, 8'hFE};
        vecs[4] = '{32'h00001234, 8'h01, 8'h0F, 2'd3, 4, 8'hFF, 8'hFF};
        vecs[5] = '{32'h00001234, 8'h01, 8'h0F, 2'd3, 1, 8'hB0, 8'hFD};
        vecs[6] = '{32'h89ABCDEF, 8'h80, 8'hFF, 2'd3, 7, 8'h00, 8'h7F};
        vecs[7] = '{32'h89ABCDEF, 8'h00, 8'hFE, 2'd3, 0, 8'hFF, 8'hFF};

        resetn = 1'b0; hex_value = '0; dp_in = '0; load = 1'b0;
        digit_en = 8'hFF; brightness = 2'd3;

        // Reset held three cycles, then first digit shows zero.
        do_reset(3);
        cycle();
        check8("post_reset_cath", cathode_array, 8'hC0);
        check8("post_reset_an", anode_array, 8'hFE);

        // Table vectors: load mid-frame 0, inspect a digit of frame 1.
        for (int k = 0; k < 8; k++) begin
            do_reset(2);
            digit_en = vecs[k].en; brightness = vecs[k].br;
            hex_value = vecs[k].v; dp_in = vecs[k].dp;
            run_until(39);
            load = 1'b1;
            cycle();
            run_until(128 + 16 * vecs[k].digit);
            $display("vector %0d value=%h digit=%0d cath=%h an=%h",
                     k, vecs[k].v, vecs[k].digit, cathode_array, anode_array);
            check8($sformatf("vec%0d_cath", k), cathode_array, vecs[k].exp_cath);
            check8($sformatf("vec%0d_an", k), anode_array, vecs[k].exp_an);
        end

        // Brightness duty over the slot of digit 2.
        for (int b = 0; b < 4; b++) begin
            if (b == 2) continue;
            do_reset(1);
            digit_en = 8'hFF; brightness = 2'(b);
            run_until(31);
            lit_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                cycle();
                if (anode_array != 8'hFF) lit_cnt++;
            end
            check_int($sformatf("duty_b%0d", b), lit_cnt, 4 * (b + 1));
        end

        // Two loads in one frame, the later exactly on the boundary.
        do_reset(1);
        digit_en = 8'hFF; brightness = 2'd3; dp_in = 8'h00;
        hex_value = 32'h11111111;
        run_until(59);
        load = 1'b1;
        cycle();
        hex_value = 32'h00000005;
        run_until(126);
        load = 1'b1;
        cycle();
        hex_value = 32'h0;
        check_int("frame_done_pulse", int'(frame_done), 1);
        bad_seen = 0;
        for (int c = 0; c < 128; c++) begin
            cycle();
            if (cathode_array == 8'hF9) bad_seen++;
            if (last_t == 128) begin
                check8("bnd_d0_cath", cathode_array, 8'h92);
                check8("bnd_d0_an", anode_array, 8'hFE);
            end
            if (last_t == 144) begin
`ifdef SEG_LZB_EN
                check8("bnd_d1_cath", cathode_array, 8'hFF);
                check8("bnd_d1_an", anode_array, 8'hFF);
`else
                check8("bnd_d1_cath", cathode_array, 8'hC0);
                check8("bnd_d1_an", anode_array, 8'hFD);
`endif
            end
        end
        check_int("stale_value_shown", bad_seen, 0);

        // Reset mid-frame discards a pending load.
        do_reset(1);
        hex_value = 32'hAAAAAAAA;
        run_until(29);
        load = 1'b1;
        cycle();
        run_until(70);
        do_reset(1);
        run_until(128);
        check8("reset_discard_cath", cathode_array, 8'hC0);
        check8("reset_discard_an", anode_array, 8'hFE);

`ifdef SEG_LZB_EN
        do_reset(1);
        dp_in = 8'h00;
        run_until(0);
        check8("lzb_zero_d0", cathode_array, 8'hC0);
        run_until(16);
        check8("lzb_zero_d1", anode_array, 8'hFF);
        hex_value = 32'h000A0000;
        load = 1'b1;
        cycle();
        run_until(128 + 64);
        check8("lzb_a_d4_cath", cathode_array, 8'h88);
        check8("lzb_a_d4_an", anode_array, 8'hEF);
        run_until(128 + 80);
        check8("lzb_a_d5_cath", cathode_array, 8'hFF);
        check8("lzb_a_d5_an", anode_array, 8'hFF);
`endif

        // Randomised run against the model, with occasional resets.
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                hex_value = $urandom;
                dp_in     = 8'($urandom);
                load      = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) begin
                digit_en   = 8'($urandom);
                brightness = 2'($urandom);
            end
            resetn = ($urandom_range(0, 999) != 0);
            cycle();
        end
        resetn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segment_hex_mux.md
Name: segment_hex_mux

Overview:
- Parametrised multiplexed 7-segment hex display driver; next generation of the team's fixed 8-digit hex display block.
- Displays a NUM_DIGITS-nibble value on a common-anode display, with per-digit decimal points, a digit-enable mask, PWM brightness and tear-free frame-synchronous value update.
- Sits between the SoC register interface (load strobe) and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits and anodes (1..16).
- CNT_W, 16, slot counter width; each digit slot lasts 2^CNT_W clk cycles.
- BRIGHT_W, 3, brightness input width; CNT_W >= BRIGHT_W required.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- hex_value  in  4*NUM_DIGITS  value to display; nibble i drives digit i (digit 0 = LS nibble).
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- load  in  1  single-cycle strobe; captures hex_value and dp_in.
- digit_en  in  NUM_DIGITS  live digit mask, 1 = digit may light.
- brightness  in  BRIGHT_W  duty level; 0 = dimmest non-off, all-ones = 100%.
- cathode_array  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- anode_array  out  NUM_DIGITS  active-low digit selects; bit i = digit i.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (resetn=0 at posedge): anode_array all ones, cathode_array 8'hFF, frame_done 0. Slot counter, digit index, staging, shadow and pending all 0.
- Slot counter: increments every cycle and wraps 2^CNT_W-1 -> 0. At the terminal count the digit index advances and wraps NUM_DIGITS-1 -> 0.
- Frame boundary: terminal count with index = NUM_DIGITS-1. frame_done = 1 in the following cycle only.
- Load handshake:
  - load=1 copies hex_value and dp_in into staging and sets pending.
  - At a frame boundary with pending=1, staging copies to shadow and pending clears.
  - If load coincides with a boundary, shadow takes the incoming hex_value and dp_in directly and pending clears.
  - Multiple loads within one frame: last one wins.
  - The displayed value only changes at frame boundaries.
- Segment decode (active low, from shadow nibble of current index):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.
  - Bit 7 is cleared when the dp bit for that digit is 1.
- Anode drive:
  - Exactly one bit low (bit = index) when the digit is lit, otherwise all ones.
  - The digit is lit when digit_en[index]=1 and counter[CNT_W-1 -: BRIGHT_W] <= brightness.
  - Duty = (brightness+1)/2^BRIGHT_W.
  - digit_en and brightness are sampled live, not shadowed.
- Latency: cathode_array and anode_array are registered, one cycle after the counter/index state they decode.
- Blanked digit: cathode_array = 8'hFF with anode all ones (ghost-free).
- Reset mid-frame: immediate return to reset state next cycle; the pending load is discarded.

Optional Feature:
- Macro SEG_LZB_EN enables leading-zero blanking.
- When defined:
  - Digits above the most-significant non-zero shadow nibble are blanked (anode high, cathode FF), unless their dp bit is set.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking is applied in addition to digit_en.
- When undefined: all enabled digits always display, zeros included.

Test Plan (NUM_DIGITS=8, CNT_W=4, BRIGHT_W=2 unless noted):
- Reset held 3 cycles, then released -> anode FF, cathode FF, frame_done 0 during reset. After release, digit 0 shows shadow 0 (cathode C0, anode FE).
- load hex_value=32'h89ABCDEF mid-frame -> display unchanged until boundary. Next frame, digit0 cathode 8E/anode FE ... digit7 cathode 80/anode 7F. frame_done pulses every 128 cycles.
- brightness=2'b01 with digit_en=8'hFF -> each digit is lit for 8 of 16 cycles (top two counter bits 00,01), then anode FF. brightness=2'b11 -> lit all 16 cycles.
- digit_en=8'h0F, dp_in=8'h01, value 32'h00001234 -> digits 4-7 anode high. Digit0 cathode 19 (4 with dp).
- load asserted exactly on the boundary cycle with 32'h00000005, plus an earlier load of 32'h11111111 in the same frame -> next frame shows 00000005 and the 11111111 value is never displayed.
- With SEG_LZB_EN defined, value 32'h00000000 -> only digit 0 lit, showing C0. Value 32'h000A0000 -> digits 0-4 lit, digits 5-7 blanked.
